// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch slice: default widths,
// instruction field positions, the NOP encoding and the fetch FSM states.
package inst_fetch_pkg;

    localparam int PC_W_DEF   = 8;
    localparam int INST_W_DEF = 16;

    // Instruction word layout: [15:12] opcode, [11:8] reg A, [7:4] reg B, [7:0] imm
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;
    localparam int REGA_MSB   = 11;
    localparam int REGA_LSB   = 8;
    localparam int REGB_MSB   = 7;
    localparam int REGB_LSB   = 4;
    localparam int IMM_MSB    = 7;
    localparam int IMM_LSB    = 0;

    // All-zero word decodes as NOP; presented whenever the buffer is empty
    localparam logic [INST_W_DEF-1:0] NOP_INST = 16'h0000;

    // IDLE: no memory request outstanding; WAIT: mem_req high, awaiting mem_ack
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch_fifo2.sv
// inst_fifo2: two-entry in-order instruction buffer with push, pop and flush.
// Simultaneous push and pop keeps occupancy and ordering; flush wins over both.
// Storage is not reset: only the occupancy and read pointer are control state.
module inst_fetch_fifo2
    import inst_fetch_pkg::*;
#(
    parameter int W = INST_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [1:0]   count_q, count_d;
    logic         rd_q, rd_d;
    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         wr_idx;

    // Next occupancy, read pointer and slot contents
    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        // Tail slot is rd + count (mod 2); when full with a pop this is the slot being freed
        wr_idx  = rd_q ^ count_q[0];
        if (flush) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_d = ~rd_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push) begin
                if (wr_idx) begin
                    slot1_d = push_data;
                end else begin
                    slot0_d = push_data;
                end
            end
        end
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
        end
    end

    // Instruction storage, no reset needed
    always_ff @(posedge clk) begin
        slot0_q <= slot0_d;
        slot1_q <= slot1_d;
    end

    assign count = count_q;
    assign head  = rd_q ? slot1_q : slot0_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, reads program memory over a req/ack
// handshake (one request outstanding), buffers up to two words and presents
// them in order to the instruction register. jmp flushes and redirects; a
// request already in flight is left to complete and its data is discarded.
// Optional feature: define FETCH_BOUNDS_EN to refuse fetches above PC_LIMIT
// and raise a sticky fault (cleared by reset or an in-range jmp).
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INST_W   = INST_W_DEF,
    parameter logic [PC_W-1:0] PC_RESET = '0,
    parameter logic [PC_W-1:0] PC_LIMIT = '1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic [PC_W-1:0]   mem_addr,
    input  logic              mem_ack,
    input  logic [INST_W-1:0] mem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_take,
    input  logic              jmp,
    input  logic [PC_W-1:0]   jmp_target,
    input  logic              halt,
    output logic [PC_W-1:0]   pc_next,
    output logic              fault
);

    fetch_state_e      state_q, state_d;
    logic              req_q, req_d;
    logic [PC_W-1:0]   addr_q, addr_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              drop_q, drop_d;

    logic [1:0]        fifo_count;
    logic [INST_W-1:0] fifo_head;
    logic              buf_valid;
    logic              ack_accept;
    logic              push;
    logic              pop;
    logic [1:0]        count_post;
    logic              room;
    logic              want_issue;
    logic              issue;
    logic              in_bounds;
    logic              fetch_blocked;

`ifdef FETCH_BOUNDS_EN
    logic              fault_q, fault_d;

    assign in_bounds     = (pc_q <= PC_LIMIT);
    assign fetch_blocked = fault_q;
    assign fault         = fault_q;
`else
    logic              unused_pc_limit;

    assign in_bounds       = 1'b1;
    assign fetch_blocked   = 1'b0;
    assign fault           = 1'b0;
    assign unused_pc_limit = ^PC_LIMIT;
`endif

    assign buf_valid  = (fifo_count != 2'd0);
    // Stray acks outside WAIT (e.g. after a reset mid-request) are ignored
    assign ack_accept = (state_q == ST_WAIT) && mem_ack;
    // A redirect flushes the buffer, so it overrides both the take and a coincident ack
    assign pop        = inst_take && buf_valid && !jmp;
    assign push       = ack_accept && !drop_q && !jmp;
    // Issue uses post-take occupancy so a take frees a slot in the same cycle
    assign count_post = fifo_count - {1'b0, pop};
    assign room       = (count_post < 2'd2);
    assign want_issue = (state_q == ST_IDLE) && !halt && !jmp && !fetch_blocked && room;
    assign issue      = want_issue && in_bounds;

    // Fetch FSM next state, PC advance, redirect and drop bookkeeping
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_WAIT;
                    addr_d  = pc_q;
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            ST_WAIT: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (jmp) begin
                    // Request cannot be withdrawn; remember to discard its data
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (jmp) begin
            pc_d = jmp_target;
        end
        req_d = (state_d == ST_WAIT);
    end

`ifdef FETCH_BOUNDS_EN
    // Sticky bounds fault: set on a refused fetch, cleared by an in-range redirect
    always_comb begin
        fault_d = fault_q;
        if (jmp) begin
            fault_d = fault_q && (jmp_target > PC_LIMIT);
        end else if (want_issue && !in_bounds) begin
            fault_d = 1'b1;
        end
    end
`endif

    // Fetch FSM state and registered memory-side outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            pc_q    <= PC_RESET;
            drop_q  <= 1'b0;
`ifdef FETCH_BOUNDS_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
`ifdef FETCH_BOUNDS_EN
            fault_q <= fault_d;
`endif
        end
    end

    inst_fetch_fifo2 #(
        .W(INST_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .flush     (jmp),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign pc_next    = pc_q;
    assign inst_valid = buf_valid;
    assign inst       = buf_valid ? fifo_head : INST_W'(NOP_INST);

endmodule
